uart_fifo: RTL

Synchronous first-word-fall-through (FWFT) FIFO that buffers 16-bit words on both sides of `uart_ctl`. One instance sits upstream of the controller's transmit path: its `rd_data`/`empty`/`rd_en` drive `tx_data`/`tx_empty`/`tx_fifo_en`. A second instance sits downstream of the receive path: `rx_data`/`rx_fifo_en` drive `wr_data`/`wr_en`, and `full` returns to `rx_full`. The controller samples the head word in the same cycle it pops, so the head word must be present on `rd_data` whenever `empty` is low.

---
 rtl/uart_pkg.sv | 13 +
 rtl/uart_fifo_mem.sv | 26 ++
 rtl/uart_fifo.sv | 112 +++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART datapath constants; instantiating blocks take their FIFO
// word width and depth defaults from here.
package uart_pkg;

  localparam int UART_WORD_W     = 16;
  localparam int UART_FIFO_DEPTH = 16;

  // Occupancy counter width: must represent 0..depth inclusive.
  function automatic int fifo_count_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// DEPTH x WIDTH register array with one synchronous write port and an
// asynchronous read port, used as FIFO storage.
module uart_fifo_mem #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: storage has no reset; validity is tracked by the FIFO's count,
  // so clearing the array would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_fifo.sv
// First-word-fall-through FIFO for the UART controller's TX/RX paths.
// Define UART_FIFO_ERR_EN to build the sticky overflow/underflow flags.
module uart_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH     = UART_WORD_W,
  parameter int DEPTH     = UART_FIFO_DEPTH,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  output logic                     full,
  output logic                     almost_full,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     empty,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow,
  input  logic                     err_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = fifo_count_w(DEPTH);

  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [WIDTH-1:0] mem_rdata;
  logic             push_ok;
  logic             pop_ok;

  // Flags decode only registered count, never wr_en/rd_en.
  assign full         = (count == CW'(DEPTH));
  assign empty        = (count == '0);
  assign almost_full  = (count >= CW'(AF_THRESH));
  assign almost_empty = (count <= CW'(AE_THRESH));

  // A pop in the same cycle frees the slot, so a push into a full FIFO is
  // accepted alongside it.
  assign push_ok = wr_en && (!full || rd_en) && !flush;
  assign pop_ok  = rd_en && !empty && !flush;

  uart_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (push_ok),
    .waddr (wr_ptr),
    .wdata (wr_data),
    .raddr (rd_ptr),
    .rdata (mem_rdata)
  );

  assign rd_data = empty ? '0 : mem_rdata;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef UART_FIFO_ERR_EN
  logic ovf_set;
  logic unf_set;

  assign ovf_set = wr_en && full && !rd_en && !flush;
  assign unf_set = rd_en && empty && !flush;

  // A new error in the same cycle as err_clr wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (ovf_set)      overflow <= 1'b1;
      else if (err_clr) overflow <= 1'b0;
      if (unf_set)      underflow <= 1'b1;
      else if (err_clr) underflow <= 1'b0;
    end
  end
`else
  logic unused_err_clr;

  assign unused_err_clr = err_clr;
  assign overflow       = 1'b0;
  assign underflow      = 1'b0;
`endif

endmodule
